// File: rtl/cgra_exec_ctrl_pkg.sv
// Shared CGRA definitions: controller state encoding and pipeline drain defaults.
// Used by the execution controller, the BRAM interface and the torus array.
package cgra_exec_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } cgra_state_e;

    localparam int CGRA_DRAIN_CYCLES = 4;

    // Width of a counter that must reach 'last'; never narrower than one bit.
    function automatic int drain_cnt_w(input int last);
        return (last < 1) ? 1 : $clog2(last + 1);
    endfunction

endpackage

// File: rtl/cgra_exec_ctrl_if.sv
// Software-facing control bundle of the CGRA execution controller.
// master = host/software side, slave = controller.
interface cgra_exec_ctrl_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 Computation_Start;
    logic [CNT_WIDTH-1:0] Cfg_Cycles;
    logic [CNT_WIDTH-1:0] Cfg_Iter;
    logic                 PE_Array_Busy;
    logic [CNT_WIDTH-1:0] Inst_Addr;
    logic [CNT_WIDTH-1:0] Iter_Cnt;
    logic                 Computation_Done;

    modport master (
        output Computation_Start, Cfg_Cycles, Cfg_Iter,
        input  PE_Array_Busy, Inst_Addr, Iter_Cnt, Computation_Done
    );

    modport slave (
        input  Computation_Start, Cfg_Cycles, Cfg_Iter,
        output PE_Array_Busy, Inst_Addr, Iter_Cnt, Computation_Done
    );
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for a single-bit level crossing into the clk domain.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/cgra_exec_ctrl.sv
// CGRA execution controller: sequences instruction addresses over a configured
// number of kernel iterations, drains the PE pipeline, and reports completion.
module cgra_exec_ctrl
    import cgra_exec_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH    = 16,
    parameter int DRAIN_CYCLES = CGRA_DRAIN_CYCLES
) (
    input  logic            Clk,
    input  logic            Resetn,
    cgra_exec_ctrl_if.slave bus
);
    localparam int DRAIN_LAST = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
    localparam int DRAIN_W    = drain_cnt_w(DRAIN_LAST);

    cgra_state_e          state_q;
    logic [CNT_WIDTH-1:0] cyc_q;
    logic [CNT_WIDTH-1:0] iter_q;
    logic [CNT_WIDTH-1:0] addr_q;
    logic [CNT_WIDTH-1:0] iter_cnt_q;
    logic [DRAIN_W-1:0]   drain_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 start_s;
    logic                 start_s_q;

    logic start_rise;
    logic addr_last;
    logic iter_last;
    logic drain_last;

    sync2 u_start_sync (
        .clk   (Clk),
        .rst_n (Resetn),
        .d_i   (bus.Computation_Start),
        .q_o   (start_s)
    );

    // A run begins only on a fresh rising edge so a level left high cannot retrigger.
    assign start_rise = start_s & ~start_s_q;
    assign addr_last  = (addr_q == cyc_q - CNT_WIDTH'(1));
    assign iter_last  = (iter_cnt_q == iter_q - CNT_WIDTH'(1));
    assign drain_last = (drain_q == DRAIN_W'(DRAIN_LAST));

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= ST_IDLE;
            cyc_q      <= '0;
            iter_q     <= '0;
            addr_q     <= '0;
            iter_cnt_q <= '0;
            drain_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            start_s_q  <= 1'b0;
        end else begin
            start_s_q <= start_s;
            case (state_q)
                ST_IDLE: begin
                    if (start_rise) begin
                        cyc_q      <= bus.Cfg_Cycles;
                        iter_q     <= bus.Cfg_Iter;
                        addr_q     <= '0;
                        iter_cnt_q <= '0;
                        drain_q    <= '0;
                        if (bus.Cfg_Cycles == '0 || bus.Cfg_Iter == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    if (!start_s) begin
                        state_q    <= ST_IDLE;
                        busy_q     <= 1'b0;
                        addr_q     <= '0;
                        iter_cnt_q <= '0;
                        drain_q    <= '0;
                    end else if (addr_last) begin
                        if (iter_last) begin
                            drain_q <= '0;
                            if (DRAIN_CYCLES == 0) begin
                                state_q <= ST_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= ST_DRAIN;
                            end
                        end else begin
                            addr_q     <= '0;
                            iter_cnt_q <= iter_cnt_q + CNT_WIDTH'(1);
                        end
                    end else begin
                        addr_q <= addr_q + CNT_WIDTH'(1);
                    end
                end

                ST_DRAIN: begin
                    if (!start_s) begin
                        state_q    <= ST_IDLE;
                        busy_q     <= 1'b0;
                        addr_q     <= '0;
                        iter_cnt_q <= '0;
                        drain_q    <= '0;
                    end else if (drain_last) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q + DRAIN_W'(1);
                    end
                end

                ST_DONE: begin
                    // Completion is held for software until it withdraws the start level.
                    if (!start_s) begin
                        state_q    <= ST_IDLE;
                        done_q     <= 1'b0;
                        addr_q     <= '0;
                        iter_cnt_q <= '0;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PE_Array_Busy    = busy_q;
    assign bus.Inst_Addr        = addr_q;
    assign bus.Iter_Cnt         = iter_cnt_q;
    assign bus.Computation_Done = done_q;
endmodule

// File: doc/cgra_exec_ctrl.md
CGRA_EXEC_CTRL -- requirements
Module: cgra_exec_ctrl

Interface
REQ-001 Parameters SHALL be: CNT_WIDTH, default 16, width of schedule and iteration counters; DRAIN_CYCLES, default 4, PE pipeline drain length after the last instruction.
REQ-002 Port Clk SHALL be an input, 1 bit: the single clock for all state.
REQ-003 Port Resetn SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-004 Port Computation_Start SHALL be an input, 1 bit: software start level, asynchronous to Clk.
REQ-005 Port Cfg_Cycles SHALL be an input, CNT_WIDTH bits: instructions per kernel iteration.
REQ-006 Port Cfg_Iter SHALL be an input, CNT_WIDTH bits: kernel iteration count.
REQ-007 Port PE_Array_Busy SHALL be an output, 1 bit: the PE array is executing or draining.
REQ-008 Port Inst_Addr SHALL be an output, CNT_WIDTH bits: PE instruction-memory read address.
REQ-009 Port Iter_Cnt SHALL be an output, CNT_WIDTH bits: current iteration index.
REQ-010 Port Computation_Done SHALL be an output, 1 bit: kernel-complete flag returned to software.

Function
REQ-011 Computation_Start SHALL pass through a 2-flop synchronizer to produce Start_S; no other logic samples the raw input.
REQ-012 The FSM SHALL have exactly the states IDLE, RUN, DRAIN and DONE.
REQ-013 In IDLE with Start_S=1, Cfg_Cycles and Cfg_Iter SHALL be latched; the FSM then enters RUN with Inst_Addr=0 and Iter_Cnt=0.
REQ-014 If the latched Cfg_Cycles=0 or Cfg_Iter=0, IDLE SHALL go directly to DONE and PE_Array_Busy SHALL never assert.
REQ-015 In RUN, Inst_Addr SHALL increment by 1 each cycle.
REQ-016 In RUN, when Inst_Addr = Cfg_Cycles-1 and Iter_Cnt < Cfg_Iter-1, Inst_Addr SHALL wrap to 0 and Iter_Cnt SHALL increment, with no bubble cycle.
REQ-017 In RUN, when Inst_Addr = Cfg_Cycles-1 and Iter_Cnt = Cfg_Iter-1, the FSM SHALL enter DRAIN and Inst_Addr SHALL hold.
REQ-018 DRAIN SHALL last exactly DRAIN_CYCLES cycles and then enter DONE; for DRAIN_CYCLES=0, RUN SHALL go directly to DONE.
REQ-019 PE_Array_Busy SHALL be 1 only in RUN and DRAIN, and SHALL be registered (no combinational path from Start_S).
REQ-020 Computation_Done SHALL be 1 only in DONE; DONE SHALL hold until Start_S=0, then return to IDLE.
REQ-021 If Start_S drops during RUN or DRAIN, the FSM SHALL abort to IDLE the next cycle, Computation_Done SHALL stay 0, and the counters SHALL clear.
REQ-022 Changes to Cfg_* after latching SHALL have no effect until the next IDLE->RUN transition.
REQ-023 Start_S held high after IDLE is re-entered SHALL NOT restart the FSM; a new run requires Start_S to go 0 and then 1 (rising-edge qualified).
REQ-024 All counters SHALL be CNT_WIDTH unsigned; the total cycle count is up to Cfg_Cycles*Cfg_Iter with no overflow flag.

Reset
REQ-025 Resetn=0 SHALL asynchronously force IDLE, synchronizer flops=0, Inst_Addr=0, Iter_Cnt=0, PE_Array_Busy=0, Computation_Done=0 and the latched config=0.
REQ-026 Reset asserted mid-RUN SHALL drop PE_Array_Busy in the same instant; after release, operation SHALL start only on a fresh Start_S rising edge.

Structure
REQ-027 The state encoding and the DRAIN_CYCLES default SHALL live in the shared CGRA package used by the BRAM interface and the torus array.
REQ-028 The 2-flop synchronizer SHALL be a separate sub-module, sync2, which is reusable by the BRAM interface.
REQ-029 All remaining logic SHALL be a single flat module.

Verification
REQ-030 Cfg_Cycles=4, Cfg_Iter=2, DRAIN_CYCLES=3, start pulse -> Inst_Addr sequence 0,1,2,3,0,1,2,3; Busy high for 11 cycles, rising 3 cycles after Start; then Done=1.
REQ-031 Cfg_Iter=0 -> Done=1 within 3 cycles of Start, with Busy never 1.
REQ-032 Start deasserted at Inst_Addr=2 of the first iteration -> IDLE; Done stays 0; counters read 0.
REQ-033 Done=1 with Start held 20 cycles -> Done holds; Start low -> Done=0 within 3 cycles; no restart until the next Start rise.
REQ-034 Resetn pulsed low mid-DRAIN -> Busy=0 immediately; no Done; a later Start runs a full kernel correctly.
REQ-035 Cfg_Cycles changed 5->9 during RUN -> iteration length stays 5.
